ysyx_24100012_core_ctrl: RTL and testbench

YSYX_24100012_CORE_CTRL -- requirements
Module: ysyx_24100012_core_ctrl

---
 rtl/ysyx_24100012_core_ctrl_if.sv | 27 ++
 rtl/ysyx_24100012_core_ctrl.sv | 63 ++++++
 tb/tb_ysyx_24100012_core_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ysyx_24100012_core_ctrl_if.sv
// ysyx_24100012_core_ctrl_if: controller bus (fetch, decoder, lsu, writeback, status, counters); master = controller, slave = environment
interface ysyx_24100012_core_ctrl_if #(parameter int DATA_WIDTH = 32);
  logic ifu_req;
  logic ifu_valid;
  logic [DATA_WIDTH-1:0] ifu_rdata;
  logic [DATA_WIDTH-1:0] inst;
  logic [2:0] inst_type;
  logic dec_wen;
  logic lsu_req;
  logic lsu_wen;
  logic lsu_done;
  logic rf_wen;
  logic pc_en;
  logic halt;
  logic err;
  logic [2:0] state;
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;
  modport master (
    output ifu_req, inst, lsu_req, lsu_wen, rf_wen, pc_en, halt, err, state, cycle_cnt, instret_cnt,
    input ifu_valid, ifu_rdata, inst_type, dec_wen, lsu_done
  );
  modport slave (
    input ifu_req, inst, lsu_req, lsu_wen, rf_wen, pc_en, halt, err, state, cycle_cnt, instret_cnt,
    output ifu_valid, ifu_rdata, inst_type, dec_wen, lsu_done
  );
endinterface

// File: rtl/ysyx_24100012_core_ctrl.sv
// ysyx_24100012_core_ctrl: multi-cycle core sequencer; ports clk, rst (async high), bus (master side of the controller interface)
module ysyx_24100012_core_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  ysyx_24100012_core_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR} state_t;
  state_t st, nxt;
  logic [31:0] wcnt;
  logic [DATA_WIDTH-1:0] inst_q;
  logic is_load, is_store, tmo;
  assign bus.inst = inst_q;
  assign bus.state = st;
  always_comb begin
    is_load = inst_q[6:0] == 7'b0000011;
    is_store = inst_q[6:0] == 7'b0100011;
    // wcnt counts silent cycles already spent, so the last allowed cycle is TIMEOUT-1
    tmo = (TIMEOUT != 0) && (wcnt == 32'(TIMEOUT - 1));
    nxt = st;
    case (st)
      IDLE: nxt = FETCH;
      FETCH: nxt = bus.ifu_valid ? DECODE : tmo ? ERR : FETCH;
      DECODE: nxt = (bus.inst_type == 3'b111) ? ERR : (bus.inst_type == 3'b110 && inst_q[20]) ? HALT : EXEC;
      EXEC: nxt = (is_load || is_store) ? MEM : WB;
      MEM: nxt = bus.lsu_done ? WB : tmo ? ERR : MEM;
      WB: nxt = FETCH;
      default: nxt = st;
    endcase
  end
  // strobes are registered from the next state so they line up with the state they belong to
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      wcnt <= '0;
      inst_q <= '0;
      bus.ifu_req <= 1'b0;
      bus.lsu_req <= 1'b0;
      bus.lsu_wen <= 1'b0;
      bus.rf_wen <= 1'b0;
      bus.pc_en <= 1'b0;
      bus.halt <= 1'b0;
      bus.err <= 1'b0;
      bus.cycle_cnt <= '0;
      bus.instret_cnt <= '0;
    end else begin
      st <= nxt;
      if (st == FETCH && bus.ifu_valid) inst_q <= bus.ifu_rdata;
      wcnt <= (st == nxt && (st == FETCH || st == MEM)) ? wcnt + 32'd1 : '0;
      bus.ifu_req <= nxt == FETCH;
      bus.lsu_req <= nxt == MEM;
      bus.lsu_wen <= nxt == MEM && is_store;
      bus.pc_en <= nxt == WB;
      bus.rf_wen <= nxt == WB && ((bus.dec_wen && bus.inst_type != 3'b010 && bus.inst_type != 3'b100) || is_load);
      bus.halt <= nxt == HALT;
      bus.err <= nxt == ERR;
      if (st != IDLE && st != HALT && st != ERR) bus.cycle_cnt <= bus.cycle_cnt + 32'd1;
      if (st == WB) bus.instret_cnt <= bus.instret_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_ysyx_24100012_core_ctrl.sv
// tb_ysyx_24100012_core_ctrl: random and directed instruction streams checked against a per-instruction state-sequence model
module tb_ysyx_24100012_core_ctrl;
  localparam int TMO = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ret = 0;
  logic [31:0] last_inst = '0;
  ysyx_24100012_core_ctrl_if #(.DATA_WIDTH(32)) bus ();
  ysyx_24100012_core_ctrl #(.DATA_WIDTH(32), .TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset();
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_inst", bus.inst, 32'd0);
    chk("rst_strobes", 32'({bus.ifu_req, bus.lsu_req, bus.lsu_wen, bus.rf_wen, bus.pc_en}), 32'd0);
    chk("rst_flags", 32'({bus.halt, bus.err}), 32'd0);
    chk("rst_cycle", bus.cycle_cnt, 32'd0);
    chk("rst_instret", bus.instret_cnt, 32'd0);
  endtask
  task automatic absorb(input int fs, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus.ifu_valid = 1'($urandom);
      bus.ifu_rdata = $urandom;
      bus.lsu_done = 1'($urandom);
      chk("abs_state", 32'(bus.state), 32'(fs));
      chk("abs_halt", 32'(bus.halt), 32'(fs == 6));
      chk("abs_err", 32'(bus.err), 32'(fs == 7));
      chk("abs_strobes", 32'({bus.ifu_req, bus.lsu_req, bus.lsu_wen, bus.rf_wen, bus.pc_en}), 32'd0);
      chk("abs_cycle", bus.cycle_cnt, 32'(cyc));
      chk("abs_instret", bus.instret_cnt, 32'(ret));
      chk("abs_inst", bus.inst, last_inst);
    end
  endtask
  task automatic rst_pulse();
    #2 rst = 1'b1;
    #1 chk_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    ret = 0;
    last_inst = '0;
  endtask
  // f: silent fetch cycles before valid (>=TMO never answers); m: silent MEM cycles; cut>0 stops after that many cycles
  task automatic run(input logic [31:0] rd, input logic [2:0] ty, input logic wen, input int f, input int m, input int cut);
    int q[$];
    int fin;
    int mi;
    logic ld, sv, rfw;
    ld = rd[6:0] == 7'b0000011;
    sv = rd[6:0] == 7'b0100011;
    rfw = (wen && ty != 3'b010 && ty != 3'b100) || ld;
    fin = 1;
    for (int i = 0; i < ((f < TMO) ? f + 1 : TMO); i++) q.push_back(1);
    if (f >= TMO) fin = 7;
    else begin
      q.push_back(2);
      if (ty == 3'b111) fin = 7;
      else if (ty == 3'b110 && rd[20]) fin = 6;
      else begin
        q.push_back(3);
        if (ld || sv) for (int i = 0; i < ((m < TMO) ? m + 1 : TMO); i++) q.push_back(4);
        if ((ld || sv) && m >= TMO) fin = 7;
        else q.push_back(5);
      end
    end
    if (cut > 0) begin
      while (q.size() > cut) void'(q.pop_back());
      fin = 0;
    end
    bus.inst_type = ty;
    bus.dec_wen = wen;
    mi = 0;
    foreach (q[i]) begin
      @(negedge clk);
      bus.ifu_valid = (q[i] == 1) ? (i == f) : 1'($urandom);
      bus.ifu_rdata = (q[i] == 1 && i == f) ? rd : $urandom;
      bus.lsu_done = (q[i] == 4) ? (mi == m) : 1'($urandom);
      if (q[i] == 2) last_inst = rd;
      chk("state", 32'(bus.state), 32'(q[i]));
      chk("ifu_req", 32'(bus.ifu_req), 32'(q[i] == 1));
      chk("lsu_req", 32'(bus.lsu_req), 32'(q[i] == 4));
      chk("lsu_wen", 32'(bus.lsu_wen), 32'(q[i] == 4 && sv));
      chk("pc_en", 32'(bus.pc_en), 32'(q[i] == 5));
      chk("rf_wen", 32'(bus.rf_wen), 32'(q[i] == 5 && rfw));
      chk("flags", 32'({bus.halt, bus.err}), 32'd0);
      chk("inst", bus.inst, last_inst);
      chk("cycle_cnt", bus.cycle_cnt, 32'(cyc));
      chk("instret_cnt", bus.instret_cnt, 32'(ret));
      if (q[i] == 4) mi++;
      cyc++;
      if (q[i] == 5) ret++;
    end
    if (fin > 1) absorb(fin, (fin == 6) ? 100 : 5);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] rd;
    int k;
    bus.ifu_valid = 1'b0;
    bus.ifu_rdata = '0;
    bus.inst_type = '0;
    bus.dec_wen = 1'b0;
    bus.lsu_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_reset();
    rst = 1'b0;
    run(32'h00100093, 3'b001, 1'b1, 0, 0, 0);
    run(32'h0011A023, 3'b100, 1'b0, 1, 2, 0);
    run(32'h0001A103, 3'b001, 1'b1, 0, 0, 0);
    run(32'h0001A103, 3'b001, 1'b0, 3, 3, 0);
    for (int n = 0; n < 25; n++) begin
      rd = $urandom;
      k = $urandom_range(0, 2);
      rd[6:0] = (k == 0) ? 7'h03 : (k == 1) ? 7'h23 : 7'h13;
      run(rd, 3'($urandom_range(0, 6)), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end
    run(32'h0011A023, 3'b100, 1'b0, 0, 9, 0);
    rst_pulse();
    run(32'h00100073, 3'b110, 1'b0, 0, 0, 0);
    rst_pulse();
    run(32'h00000013, 3'b000, 1'b1, 9, 0, 0);
    rst_pulse();
    run(32'h00000013, 3'b111, 1'b1, 1, 0, 0);
    rst_pulse();
    run(32'h0011A023, 3'b100, 1'b0, 0, 9, 4);
    rst_pulse();
    run(32'h0001A103, 3'b001, 1'b1, 3, 1, 0);
    run(32'h00100093, 3'b001, 1'b1, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
